pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_div_cycle_counter.sv | 17 +
 rtl/pipeline_ctrl.sv | 59 +++++
 tb/tb_pipeline_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: stage indices, controller states and shared constants for pipeline control
package pipeline_ctrl_pkg;
   localparam int STAGE_IF = 0;
   localparam int STAGE_ID = 1;
   localparam int STAGE_EX = 2;
   localparam int STAGE_MEM = 3;
   localparam int STAGE_WB = 4;
   localparam int NSTAGE = 5;
   localparam int CNT_W = 6;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
   typedef enum logic [1:0] {RUN = 2'd0, DIV = 2'd1, FLUSH = 2'd2} state_t;
   // Hold mask for a request at stage k: that stage and everything upstream of it.
   function automatic logic [NSTAGE-1:0] stall_upto(input int k);
      return NSTAGE'((1 << (k + 1)) - 1);
   endfunction
endpackage

// File: rtl/pipeline_ctrl_div_cycle_counter.sv
// div_cycle_counter: down-counter timing a multi-cycle divide in EX
module div_cycle_counter
   import pipeline_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] count;
   always_ff @(posedge clk)
      count <= (!rst || clear) ? '0 : load ? load_val : dec ? count - 1'b1 : count;
   assign zero = count == '0;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall prioritisation, divide occupancy and exception flush/redirect control
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_mem,
   input  logic              div_req,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic [31:0]       epc,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              div_busy,
   output logic              div_done
);
   state_t state, state_nx;
   logic accept, ex_req, zero, load, clear, dec, div_exit;
   div_cycle_counter u_cnt (
      .clk(clk),
      .rst(rst),
      .load(load),
      .clear(clear),
      .dec(dec),
      .load_val(CNT_W'(DIV_CYCLES - 1)),
      .zero(zero)
   );
   always_ff @(posedge clk)
      state <= !rst ? RUN : state_nx;
   // Exceptions wait for MEM to be ready; the refetch cycle ignores new requests.
   always_comb begin
      accept = (exc_req || eret_req) && !stallreq_mem && state != FLUSH;
      ex_req = (state == DIV && !zero) || (state == RUN && div_req);
      div_exit = state == DIV && zero && !stallreq_mem;
      load = state == RUN && div_req && !stallreq_mem && !accept;
      clear = accept || div_exit;
      dec = state == DIV && !zero;
      flush = accept;
      new_pc = accept ? (exc_req ? EXC_VECTOR : epc) : '0;
      stall = accept ? '0 :
              state == FLUSH ? stall_upto(STAGE_IF) :
              stallreq_mem ? stall_upto(STAGE_MEM) :
              ex_req ? stall_upto(STAGE_EX) :
              stallreq_id ? stall_upto(STAGE_ID) :
              stallreq_if ? stall_upto(STAGE_IF) : '0;
      div_busy = state == DIV;
      div_done = state == DIV && zero && !accept;
      state_nx = accept ? FLUSH :
                 state == FLUSH ? RUN :
                 load ? DIV :
                 div_exit ? RUN : state;
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed literal checks plus randomized run against a cycle-level behavioural model
module tb_pipeline_ctrl;
   localparam int DIVC = 32;
   logic clk = 0, rst = 0;
   logic stallreq_if = 0, stallreq_id = 0, stallreq_mem = 0, div_req = 0, exc_req = 0, eret_req = 0;
   logic [31:0] epc = 0;
   logic [4:0] stall;
   logic flush, div_busy, div_done;
   logic [31:0] new_pc;
   int total = 0, bad = 0;
   bit chk_en = 0;
   bit m_busy = 0, m_refetch = 0;
   int m_left = 0;
   pipeline_ctrl #(.DIV_CYCLES(DIVC), .EXC_VECTOR(32'hBFC00380)) dut (
      .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_mem(stallreq_mem), .div_req(div_req), .exc_req(exc_req), .eret_req(eret_req),
      .epc(epc), .stall(stall), .flush(flush), .new_pc(new_pc), .div_busy(div_busy), .div_done(div_done)
   );
   always #5 clk = ~clk;
   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [4:0] deepest(input bit r0, input bit r1, input bit r2, input bit r3);
      bit r[4] = '{r0, r1, r2, r3};
      int k = -1;
      for (int i = 0; i < 4; i++) if (r[i]) k = i;
      return k < 0 ? 5'd0 : 5'((1 << (k + 1)) - 1);
   endfunction
   function automatic bit m_accept();
      return (exc_req || eret_req) && !stallreq_mem && !m_refetch;
   endfunction
   // Model: m_left = remaining EX cycles of the current divide, 1 meaning quotient ready.
   always @(negedge clk) if (chk_en) begin
      bit acc, exr;
      acc = m_accept();
      exr = m_busy ? (m_left > 1) : (!m_refetch && div_req);
      cmp("m_flush", flush, acc);
      cmp("m_new_pc", new_pc, acc ? (exc_req ? 32'hBFC00380 : epc) : 32'd0);
      cmp("m_stall", stall, acc ? 5'd0 : m_refetch ? 5'd1 : deepest(stallreq_if, stallreq_id, exr, stallreq_mem));
      cmp("m_busy", div_busy, m_busy);
      cmp("m_done", div_done, m_busy && m_left == 1 && !acc);
   end
   always @(posedge clk) begin
      if (!rst) begin
         m_busy <= 0; m_refetch <= 0; m_left <= 0;
      end else if (m_accept()) begin
         m_busy <= 0; m_refetch <= 1;
      end else if (m_refetch) m_refetch <= 0;
      else if (m_busy) begin
         if (m_left > 1) m_left <= m_left - 1;
         else if (!stallreq_mem) m_busy <= 0;
      end else if (div_req && !stallreq_mem) begin
         m_busy <= 1; m_left <= DIVC;
      end
   end
   initial begin
      int n_st, n_done, done_at;
      bit seen;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1;
      @(negedge clk);
      cmp("rst_stall", stall, 0); cmp("rst_flush", flush, 0); cmp("rst_pc", new_pc, 0);
      cmp("rst_busy", div_busy, 0); cmp("rst_done", div_done, 0);
      rst = 1; tick();
      stallreq_id = 1; stallreq_mem = 1; @(negedge clk); cmp("id_mem", stall, 5'b01111); tick();
      stallreq_id = 0; @(negedge clk); cmp("mem_only", stall, 5'b01111); tick();
      stallreq_mem = 0; stallreq_id = 1; @(negedge clk); cmp("id_only", stall, 5'b00011); tick();
      stallreq_id = 0; stallreq_if = 1; @(negedge clk); cmp("if_only", stall, 5'b00001); tick();
      stallreq_if = 0;
      div_req = 1; @(negedge clk); n_st = int'(stall[2]); tick(); div_req = 0;
      n_done = 0; done_at = -1;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         n_st += int'(stall[2]);
         if (div_done) begin n_done++; done_at = i; end
         if (i == 33) cmp("busy_after_div", div_busy, 0);
         tick();
      end
      cmp("ex_stall_cycles", n_st, 32); cmp("done_count", n_done, 1); cmp("done_cycle", done_at, 32);
      div_req = 1; tick(); div_req = 0; seen = 0;
      repeat (21) begin @(negedge clk); seen |= div_done; tick(); end
      exc_req = 1; @(negedge clk);
      cmp("exc_flush", flush, 1); cmp("exc_pc", new_pc, 32'hBFC00380); cmp("exc_stall", stall, 0);
      seen |= div_done; tick(); exc_req = 0; @(negedge clk);
      cmp("refetch_stall", stall, 5'b00001); cmp("refetch_flush", flush, 0); cmp("abort_busy", div_busy, 0);
      seen |= div_done; tick();
      repeat (3) begin @(negedge clk); seen |= div_done; tick(); end
      cmp("abort_no_done", seen, 0);
      eret_req = 1; epc = 32'h80001000; stallreq_mem = 1;
      repeat (3) begin @(negedge clk); cmp("eret_defer", flush, 0); tick(); end
      stallreq_mem = 0; @(negedge clk);
      cmp("eret_flush", flush, 1); cmp("eret_pc", new_pc, 32'h80001000); tick();
      eret_req = 0; @(negedge clk); cmp("eret_refetch", stall, 5'b00001); tick();
      div_req = 1; tick(); div_req = 0;
      repeat (31) tick();
      stallreq_mem = 1; n_done = 0;
      repeat (4) begin @(negedge clk); n_done += int'(div_done); tick(); end
      stallreq_mem = 0; @(negedge clk); n_done += int'(div_done); cmp("held_busy", div_busy, 1); tick();
      @(negedge clk); cmp("held_exit_busy", div_busy, 0); cmp("held_exit_done", div_done, 0);
      cmp("held_done_cycles", n_done, 5); tick();
      div_req = 1; tick(); div_req = 0;
      repeat (26) tick();
      rst = 0; tick(); @(negedge clk);
      cmp("mrst_stall", stall, 0); cmp("mrst_flush", flush, 0); cmp("mrst_pc", new_pc, 0);
      cmp("mrst_busy", div_busy, 0); cmp("mrst_done", div_done, 0);
      rst = 1; tick(); @(negedge clk); cmp("post_busy", div_busy, 0); cmp("post_done", div_done, 0); tick();
      for (int c = 0; c < 4000; c++) begin
         rst = $urandom_range(0, 299) != 0;
         stallreq_if = $urandom_range(0, 3) == 0;
         stallreq_id = $urandom_range(0, 3) == 0;
         stallreq_mem = $urandom_range(0, 3) == 0;
         div_req = $urandom_range(0, 5) == 0;
         exc_req = $urandom_range(0, 40) == 0;
         eret_req = $urandom_range(0, 40) == 0;
         epc = $urandom;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
